// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: round-robin share of one AND/OR/XOR/ANDN unit between
// NUM_REQ requesters, result registered into a one-entry valid/ready slot.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   req_valid/req_ready  per-requester handshake, ready is one-hot or zero
//   req_op/req_a/req_b   packed per-requester op (2b) and operands (WIDTH)
//   resp_valid/ready     result slot handshake
//   resp_data/resp_id    registered result and index of its requester
//   grant_count          accepted-request counter, only when
//                        LOGIC_OP_ARBITER_GRANT_COUNT_EN is defined
module logic_op_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     resp_valid,
    output logic [WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]          resp_id,
    input  logic                     resp_ready
`ifdef LOGIC_OP_ARBITER_GRANT_COUNT_EN
    ,
    output logic [31:0]              grant_count
`endif
);

    localparam logic [ID_W:0] NUM_L = (ID_W+1)'(NUM_REQ);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  next_ptr;
    logic [ID_W:0]    idx;
    logic             found;
    logic             can_accept;
    logic             accept;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] result;

    assign can_accept = !resp_valid || resp_ready;
    assign accept     = found && can_accept && !rst;

    // Search starts at ptr; the sum is one bit wider so the modulo
    // wrap works for non-power-of-2 NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= NUM_L) idx = idx - NUM_L;
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[WIDTH*i +: WIDTH];
                sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        case (sel_op)
            2'b00:   result = sel_a & sel_b;
            2'b01:   result = sel_a | sel_b;
            2'b10:   result = sel_a ^ sel_b;
            default: result = sel_a & ~sel_b;
        endcase
    end

    assign next_ptr = (win == ID_W'(NUM_REQ-1)) ? '0 : win + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            ptr        <= '0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_data  <= result;
            resp_id    <= win;
            ptr        <= next_ptr;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

`ifdef LOGIC_OP_ARBITER_GRANT_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)         grant_count <= '0;
        else if (accept) grant_count <= grant_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb_logic_op_arbiter: table vectors, directed corner sequences and random
// traffic against a queue-free reference model of the arbiter slot.
module tb_logic_op_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_id;
    logic        resp_ready;

    logic        rst3;
    logic [2:0]  req_valid3;
    logic [2:0]  req_ready3;
    logic [5:0]  req_op3;
    logic [95:0] req_a3;
    logic [95:0] req_b3;
    logic        resp_valid3;
    logic [31:0] resp_data3;
    logic [1:0]  resp_id3;
    logic        resp_ready3;

`ifdef LOGIC_OP_ARBITER_GRANT_COUNT_EN
    logic [31:0] grant_count;
    logic [31:0] grant_count3;
`endif

    always #5 clk = ~clk;

    logic_op_arbiter #(.NUM_REQ(4), .WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_id(resp_id), .resp_ready(resp_ready)
`ifdef LOGIC_OP_ARBITER_GRANT_COUNT_EN
        , .grant_count(grant_count)
`endif
    );

    logic_op_arbiter #(.NUM_REQ(3), .WIDTH(32)) dut3 (
        .clk(clk), .rst(rst3),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op(req_op3), .req_a(req_a3), .req_b(req_b3),
        .resp_valid(resp_valid3), .resp_data(resp_data3),
        .resp_id(resp_id3), .resp_ready(resp_ready3)
`ifdef LOGIC_OP_ARBITER_GRANT_COUNT_EN
        , .grant_count(grant_count3)
`endif
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_ptr;
    logic        m_valid;
    logic [31:0] m_data;
    int          m_id;
    int          m_cnt;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return a & ~b;
        endcase
    endfunction

    // One clock of the 4-requester DUT with inputs already driven:
    // checks the grant before the edge and the slot after it.
    task automatic cycle();
        int w;
        logic [3:0] exp_rdy;
        bit acc;
        w = -1;
        exp_rdy = '0;
        acc = 0;
        if (!rst)
            for (int k = 0; k < 4; k++)
                if (w < 0 && req_valid[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        if (w >= 0 && (!m_valid || resp_ready)) begin
            exp_rdy[w] = 1'b1;
            acc = 1;
        end
        #1;
        chk("req_ready", req_ready, exp_rdy);
        if (rst) begin
            m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
        end else if (acc) begin
            m_data  = ref_op(req_op[2*w +: 2], req_a[32*w +: 32],
                             req_b[32*w +: 32]);
            m_id    = w;
            m_valid = 1;
            m_ptr   = (w + 1) % 4;
            m_cnt++;
        end else if (m_valid && resp_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("resp_valid", resp_valid, m_valid);
        chk("resp_data", resp_data, m_data);
        chk("resp_id", resp_id, m_id[1:0]);
`ifdef LOGIC_OP_ARBITER_GRANT_COUNT_EN
        chk("grant_count", grant_count, m_cnt);
`endif
    endtask

    task automatic cycle3();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        resp_ready = 1'b1;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        vecs[0] = '{2'd0, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'hF000_000F};
        vecs[1] = '{2'd1, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'hFFF0_0FFF};
        vecs[2] = '{2'd2, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'h0FF0_0FF0};
        vecs[3] = '{2'd3, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'h00F0_00F0};
        vecs[4] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[5] = '{2'd2, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h5555_AAAA};

        m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0; m_cnt = 0;
        idle_inputs();
        rst = 1'b1;
        rst3 = 1'b1;
        req_valid3 = '0; req_op3 = '0; req_a3 = '0; req_b3 = '0;
        resp_ready3 = 1'b1;
        @(posedge clk);
        #1;

        // reset with every requester asking
        req_valid = 4'hF;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("rst_valid", resp_valid, 1'b0);
            chk("rst_data", resp_data, 32'h0);
        end
        rst = 1'b0;

        // single requester, every op
        req_valid = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            req_op[5:4]   = vecs[i].op;
            req_a[95:64]  = vecs[i].a;
            req_b[95:64]  = vecs[i].b;
            cycle();
            chk("vec_data", resp_data, vecs[i].exp);
            chk("vec_id", resp_id, 2'd2);
        end

        // round robin from ptr=0
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            req_op[2*i +: 2] = 2'(i);
            req_a[32*i +: 32] = $urandom;
            req_b[32*i +: 32] = $urandom;
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_id", resp_id, exp_order[i]);
            chk("rr_valid", resp_valid, 1'b1);
        end

        // backpressure: ptr is 1 here, load requester 1 only
        req_valid = 4'b0010;
        req_op[3:2] = 2'd1;
        req_a[63:32] = 32'h1234_5678;
        req_b[63:32] = 32'h0;
        cycle();
        req_valid = 4'hF;
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_data", resp_data, 32'h1234_5678);
            chk("bp_id", resp_id, 2'd1);
            chk("bp_ready", req_ready, 4'h0);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release", req_ready, 4'b0100);
        cycle();
        chk("bp_next_id", resp_id, 2'd2);

        // ptr is 3; only requester 1 valid, then all valid -> 2 next
        req_valid = 4'b0010;
        cycle();
        chk("skip_id", resp_id, 2'd1);
        req_valid = 4'hF;
        cycle();
        chk("skip_ptr", resp_id, 2'd2);

        // reset mid-flight with a full slot
        resp_ready = 1'b0;
        rst = 1'b1;
        cycle();
        chk("midrst_valid", resp_valid, 1'b0);
        rst = 1'b0;
        resp_ready = 1'b1;

        // random traffic
        for (int n = 0; n < 400; n++) begin
            req_valid  = 4'($urandom);
            req_op     = 8'($urandom);
            for (int i = 0; i < 4; i++) begin
                req_a[32*i +: 32] = $urandom;
                req_b[32*i +: 32] = $urandom;
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 60) == 0);
            cycle();
        end
        rst = 1'b0;

`ifdef LOGIC_OP_ARBITER_GRANT_COUNT_EN
        rst = 1'b1;
        cycle();
        chk("gc_reset", grant_count, 32'h0);
        rst = 1'b0;
        resp_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            req_valid = 4'b0001 << $urandom_range(0, 3);
            cycle();
        end
        chk("gc_count", grant_count, 32'd10);
`endif

        // NUM_REQ=3 instance: grant of 2 wraps ptr to 0
        rst3 = 1'b0;
        req_valid3 = 3'b100;
        req_op3 = 6'b01_00_00;
        req_a3[95:64] = 32'h0000_00F0;
        req_b3[95:64] = 32'h0000_000F;
        #1;
        chk("n3_ready", req_ready3, 3'b100);
        cycle3();
        chk("n3_id2", resp_id3, 2'd2);
        chk("n3_data", resp_data3, 32'h0000_00FF);
        req_valid3 = 3'b111;
        #1;
        chk("n3_wrap", req_ready3, 3'b001);
        cycle3();
        chk("n3_id0", resp_id3, 2'd0);
        req_valid3 = 3'b000;
        cycle3();
        chk("n3_drain", resp_valid3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one bitwise logic unit (AND/OR/XOR/ANDN) between NUM_REQ requesters.
- Each requester has a valid/ready request channel; round-robin arbitration.
- The result is registered into a single-entry output slot with a valid/ready response channel.
- Sits between the decode/issue logic and the shared logic datapath of the core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and result width in bits.
- ID_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant/accept; combinational, one-hot or zero.
- req_op  input  2*NUM_REQ  op per requester, slice i = [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b).
- req_a  input  WIDTH*NUM_REQ  operand A, slice i = [WIDTH*i +: WIDTH].
- req_b  input  WIDTH*NUM_REQ  operand B, same slicing.
- resp_valid  output  1  result slot holds a valid result.
- resp_data  output  WIDTH  registered result.
- resp_id  output  ID_W  index of the requester that produced resp_data.
- resp_ready  input  1  consumer accepts the result.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. Both are fixed.
- Reset values: resp_valid=0, resp_data=0, resp_id=0, priority pointer ptr=0.
  - req_ready is 0 while rst is high.
- Reset mid-operation discards any held result. No response is produced for it.
- Slot states: EMPTY (resp_valid=0) and FULL (resp_valid=1).
- can_accept = !resp_valid | resp_ready.
- Arbitration is combinational each cycle:
  - Search req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first set bit wins.
  - req_ready[winner] = can_accept. All other req_ready bits are 0.
- Accept means req_valid[w] & req_ready[w] at a rising edge. On accept:
  - resp_data <= op(req_a[w], req_b[w]).
  - resp_id <= w.
  - resp_valid <= 1.
  - ptr <= (w+1) mod NUM_REQ. For non-power-of-2 NUM_REQ, the wrap is explicit.
- Latency is 1 cycle from accept to resp_valid.
- Drain (resp_valid & resp_ready) with no accept in the same cycle: resp_valid <= 0. resp_data and resp_id keep their values.
- Simultaneous drain and accept: the slot reloads with the new result and resp_valid stays 1. This gives 1 result/cycle throughput.
- FULL and !resp_ready:
  - resp_valid, resp_data and resp_id are held stable.
  - All req_ready are 0.
  - ptr does not move.
- No req_valid set: no grant, ptr unchanged.
- Requesters may drop req_valid without being granted; there is no penalty.
- A granted requester must not depend on req_ready to raise req_valid; ready depends on valid, never the reverse.
- Fairness: a continuously asserting requester is granted within NUM_REQ accepts.

Optional Feature:
- Macro: LOGIC_OP_ARBITER_GRANT_COUNT_EN.
- When defined, add port grant_count output 32: a free-running count of accepted requests.
  - Reset to 0.
  - +1 per accept.
  - Wraps from 0xFFFFFFFF to 0.
- When undefined, the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset check: assert rst 2 cycles with all req_valid=1 -> resp_valid=0, resp_data=0, resp_id=0, req_ready=0 throughout.
- Single requester, all ops: req 2 with a=0xF0F0_00FF, b=0xFF00_0F0F, resp_ready=1, op 00/01/10/11 in turn. Each result appears 1 cycle after accept with resp_id=2:
  - AND: 0xF000_000F
  - OR: 0xFFF0_0FFF
  - XOR: 0x0FF0_0FF0
  - ANDN: 0x00F0_00F0
- Round-robin: all 4 req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0; resp_valid stays 1 every cycle after the first.
- Backpressure: slot FULL with resp_id=1, resp_data=0x1234_5678, resp_ready=0 for 5 cycles -> outputs stable, req_ready=0, ptr unchanged. Raising resp_ready accepts the next requester in the same cycle.
- Pointer wrap and skip: ptr=3, only req 1 valid -> req 1 granted, next ptr=2. With NUM_REQ=3 build, grant of 2 wraps ptr to 0.
- Reset mid-flight: slot FULL, assert rst for 1 cycle -> resp_valid=0 next cycle. With LOGIC_OP_ARBITER_GRANT_COUNT_EN, grant_count=0 after reset and equals the number of accepts after 10 random transactions.
